pkt_buf_24: RTL and testbench

PKT_BUF_24 -- requirements
Module: pkt_buf_24

---
 rtl/gearbox_pkg.sv | 10 +
 rtl/pkt_buf_24_if.sv | 30 +++
 rtl/pkt_buf_ram.sv | 24 ++
 rtl/pkt_buf_24.sv | 170 +++++++++++++++++
 tb/tb_pkt_buf_24.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gearbox_pkg.sv
// Shared constants and write-FSM state type for the gearbox packet buffer.
package gearbox_pkg;
    localparam int DATA_W       = 24;
    localparam int DEPTH_DEF    = 64;
    localparam int MAX_PKTS_DEF = 8;

    typedef logic [0:0] wr_state_t;
    localparam wr_state_t WRITE = 1'b0;
    localparam wr_state_t DROP  = 1'b1;
endpackage

// File: rtl/pkt_buf_24_if.sv
// Stream bundle between the 32-to-24 gearbox, the packet buffer and its consumer.
interface pkt_buf_24_if
    import gearbox_pkg::*;
#(
    parameter int MAX_PKTS = MAX_PKTS_DEF
);
    // Input has no backpressure: a word transfers on every clk edge with data_in_en high.
    // Output transfers on a clk edge with data_out_valid && data_out_ready; once valid is
    // raised, data_out, data_out_last and data_out_valid hold until that transfer.
    logic [DATA_W-1:0]         data_in;
    logic                      data_in_last;
    logic                      data_in_en;
    logic [DATA_W-1:0]         data_out;
    logic                      data_out_last;
    logic                      data_out_valid;
    logic                      data_out_ready;
    logic                      pkt_drop;
    logic [$clog2(MAX_PKTS):0] pkt_count;
    wr_state_t                 wr_state;

    modport master (
        output data_in, data_in_last, data_in_en, data_out_ready,
        input  data_out, data_out_last, data_out_valid, pkt_drop, pkt_count, wr_state
    );

    modport slave (
        input  data_in, data_in_last, data_in_en, data_out_ready,
        output data_out, data_out_last, data_out_valid, pkt_drop, pkt_count, wr_state
    );
endinterface

// File: rtl/pkt_buf_ram.sv
// Word store for the packet buffer: synchronous write, combinational read, {last, data}.
module pkt_buf_ram
    import gearbox_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = DATA_W + 1
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pkt_buf_24.sv
// Store-and-forward packet buffer: a packet is released only after its last word is stored.
// Define GEARBOX_PKT_LEN_EN to add the pkt_len output and its per-packet length queue.
module pkt_buf_24
    import gearbox_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int MAX_PKTS = MAX_PKTS_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    pkt_buf_24_if.slave      bus
`ifdef GEARBOX_PKT_LEN_EN
    ,
    output logic [$clog2(DEPTH):0] pkt_len
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_PKTS) + 1;
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_PKTS);

    wr_state_t         wr_state_q, wr_state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     wr_commit_q, wr_commit_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     pkt_count_q, pkt_count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_last_q, dout_last_d;
    logic              dout_valid_q, dout_valid_d;
    logic              pkt_drop_q, pkt_drop_d;
    logic              full, accept, we, commit, load, pop;
    logic [DATA_W:0]   rdata;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full   = (wr_ptr_q - rd_ptr_q) == FULL_LVL;
    assign accept = !full && (pkt_count_q < CNT_MAX);

    pkt_buf_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i ({bus.data_in_last, bus.data_in}),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rdata)
    );

    always_comb begin
        wr_state_d  = wr_state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        pkt_drop_d  = 1'b0;
        we          = 1'b0;
        commit      = 1'b0;
        case (wr_state_q)
            WRITE: begin
                if (bus.data_in_en) begin
                    if (accept) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (bus.data_in_last) begin
                            commit      = 1'b1;
                            wr_commit_d = wr_ptr_q + 1'b1;
                        end
                    end else begin
                        // Roll back the partial packet; skip the rest of it unless this was its end.
                        wr_ptr_d = wr_commit_q;
                        if (bus.data_in_last) begin
                            pkt_drop_d = 1'b1;
                        end else begin
                            wr_state_d = DROP;
                        end
                    end
                end
            end
            DROP: begin
                if (bus.data_in_en && bus.data_in_last) begin
                    wr_state_d = WRITE;
                    pkt_drop_d = 1'b1;
                end
            end
            default: wr_state_d = WRITE;
        endcase
    end

    assign pop  = dout_valid_q && bus.data_out_ready && dout_last_q;
    assign load = (rd_ptr_q != wr_commit_q) && (!dout_valid_q || bus.data_out_ready);

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        dout_d       = dout_q;
        dout_last_d  = dout_last_q;
        dout_valid_d = dout_valid_q;
        if (load) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            dout_d       = rdata[DATA_W-1:0];
            dout_last_d  = rdata[DATA_W];
            dout_valid_d = 1'b1;
        end else if (dout_valid_q && bus.data_out_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_comb begin
        case ({commit, pop})
            2'b10:   pkt_count_d = pkt_count_q + 1'b1;
            2'b01:   pkt_count_d = pkt_count_q - 1'b1;
            default: pkt_count_d = pkt_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_state_q   <= WRITE;
            wr_ptr_q     <= '0;
            wr_commit_q  <= '0;
            rd_ptr_q     <= '0;
            pkt_count_q  <= '0;
            dout_q       <= '0;
            dout_last_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            pkt_drop_q   <= 1'b0;
        end else begin
            wr_state_q   <= wr_state_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_commit_q  <= wr_commit_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_count_q  <= pkt_count_d;
            dout_q       <= dout_d;
            dout_last_q  <= dout_last_d;
            dout_valid_q <= dout_valid_d;
            pkt_drop_q   <= pkt_drop_d;
        end
    end

    assign bus.data_out       = dout_q;
    assign bus.data_out_last  = dout_last_q;
    assign bus.data_out_valid = dout_valid_q;
    assign bus.pkt_drop       = pkt_drop_q;
    assign bus.pkt_count      = pkt_count_q;
    assign bus.wr_state       = wr_state_q;

`ifdef GEARBOX_PKT_LEN_EN
    localparam int LW = (MAX_PKTS > 1) ? $clog2(MAX_PKTS) : 1;

    logic [PW-1:0] len_mem_q [MAX_PKTS];
    logic [LW-1:0] len_wr_q, len_rd_q;

    // Length queue advances in lockstep with pkt_count, so its head is the packet on data_out.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            len_wr_q <= '0;
            len_rd_q <= '0;
        end else begin
            if (commit) begin
                len_mem_q[len_wr_q] <= wr_ptr_d - wr_commit_q;
                len_wr_q <= (len_wr_q == LW'(MAX_PKTS - 1)) ? '0 : len_wr_q + 1'b1;
            end
            if (pop) begin
                len_rd_q <= (len_rd_q == LW'(MAX_PKTS - 1)) ? '0 : len_rd_q + 1'b1;
            end
        end
    end

    assign pkt_len = len_mem_q[len_rd_q];
`endif
endmodule

// File: tb/tb_pkt_buf_24.sv
// Self-checking bench for pkt_buf_24 (DEPTH=16, MAX_PKTS=8); define GEARBOX_PKT_LEN_EN to also check pkt_len.
module tb_pkt_buf_24;
    import gearbox_pkg::*;

    localparam int DEPTH    = 16;
    localparam int MAX_PKTS = 8;

    logic clk = 1'b0;
    logic reset_n;
    int   total    = 0;
    int   bad      = 0;
    int   drop_cnt = 0;

    logic [DATA_W:0]   exp_q[$];
    logic              hold_prev = 1'b0;
    logic [DATA_W+1:0] prev_out;

    pkt_buf_24_if #(.MAX_PKTS(MAX_PKTS)) bus ();

`ifdef GEARBOX_PKT_LEN_EN
    localparam int LENW = $clog2(DEPTH) + 1;
    logic [LENW-1:0] pkt_len;
    logic [LENW-1:0] len_q[$];
`endif

    pkt_buf_24 #(
        .DEPTH    (DEPTH),
        .MAX_PKTS (MAX_PKTS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef GEARBOX_PKT_LEN_EN
        ,
        .pkt_len (pkt_len)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor samples mid-cycle; inputs change at posedge+1, outputs at posedge.
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk_eq("hold", 32'({bus.data_out_valid, bus.data_out_last, bus.data_out}), 32'(prev_out));
            end
            if (bus.pkt_drop) drop_cnt++;
            if (bus.data_out_valid && bus.data_out_ready) begin
                if (exp_q.size() == 0) begin
                    chk_eq("extra_word", 32'(exp_q.size()), 32'd1);
                end else begin
                    chk_eq("dout", 32'({bus.data_out_last, bus.data_out}), 32'(exp_q.pop_front()));
                end
`ifdef GEARBOX_PKT_LEN_EN
                if (len_q.size() != 0) begin
                    chk_eq("pkt_len", 32'(pkt_len), 32'(len_q[0]));
                    if (bus.data_out_last) void'(len_q.pop_front());
                end
`endif
            end
            hold_prev = bus.data_out_valid && !bus.data_out_ready;
            prev_out  = {bus.data_out_valid, bus.data_out_last, bus.data_out};
        end
    end

    // ---------------- drivers ----------------
    task automatic send_word(input logic [DATA_W-1:0] d, input logic last);
        @(posedge clk);
        #1;
        bus.data_in      = d;
        bus.data_in_last = last;
        bus.data_in_en   = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.data_in_en   = 1'b0;
            bus.data_in_last = 1'b0;
        end
    endtask

    task automatic send_pkt(input int len, input bit keep, input bit seq);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < len; i++) begin
            d = seq ? DATA_W'(i + 1) : DATA_W'($urandom_range(1, 24'hFFFFFF));
            send_word(d, i == len - 1);
            if (keep) exp_q.push_back({i == len - 1, d});
        end
`ifdef GEARBOX_PKT_LEN_EN
        if (keep) len_q.push_back(LENW'(len));
`endif
    endtask

    task automatic drain(input string tag);
        int n = 0;
        bus.data_out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        idle(3);
        chk_eq({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        chk_eq({tag, "_cnt"}, 32'(bus.pkt_count), 32'd0);
        chk_eq({tag, "_valid"}, 32'(bus.data_out_valid), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk_eq({tag, "_valid"}, 32'(bus.data_out_valid), 32'd0);
        chk_eq({tag, "_data"}, 32'({bus.data_out_last, bus.data_out}), 32'd0);
        chk_eq({tag, "_cnt"}, 32'(bus.pkt_count), 32'd0);
        chk_eq({tag, "_drop"}, 32'(bus.pkt_drop), 32'd0);
        chk_eq({tag, "_state"}, 32'(bus.wr_state), 32'(WRITE));
    endtask

    // ---------------- scenarios ----------------
    initial begin
        logic [DATA_W-1:0] d;
        reset_n            = 1'b0;
        bus.data_in        = '0;
        bus.data_in_last   = 1'b0;
        bus.data_in_en     = 1'b0;
        bus.data_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");
        reset_n = 1'b1;

        // 5-word packet 1..5, consumer always ready
        bus.data_out_ready = 1'b1;
        send_pkt(5, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        bus.data_in_en = 1'b0;
        chk_eq("s1_lat1", 32'(bus.data_out_valid), 32'd0);
        chk_eq("s1_cnt1", 32'(bus.pkt_count), 32'd1);
        @(posedge clk);
        #1;
        chk_eq("s1_lat2", 32'(bus.data_out_valid), 32'd1);
        chk_eq("s1_first", 32'({bus.data_out_last, bus.data_out}), 32'h0000001);
        repeat (4) @(posedge clk);
        #1;
        chk_eq("s1_burst", 32'({bus.data_out_valid, bus.data_out_last, bus.data_out}), 32'h3000005);
        drain("s1");

        // two 10-word packets into 16 entries, consumer stalled: second is dropped
        bus.data_out_ready = 1'b0;
        send_pkt(10, 1'b1, 1'b0);
        send_pkt(10, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.data_in_en = 1'b0;
        chk_eq("s2_drop_pulse", 32'(bus.pkt_drop), 32'd1);
        @(posedge clk);
        #1;
        chk_eq("s2_drop_end", 32'(bus.pkt_drop), 32'd0);
        chk_eq("s2_cnt", 32'(bus.pkt_count), 32'd1);
        chk_eq("s2_state", 32'(bus.wr_state), 32'(WRITE));
        drain("s2");

        // nine 1-word packets: the ninth exceeds MAX_PKTS
        bus.data_out_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_pkt(1, i < 8, 1'b0);
        idle(2);
        chk_eq("s3_cnt", 32'(bus.pkt_count), 32'd8);
        chk_eq("s3_drops", 32'(drop_cnt), 32'd2);
        send_word(24'h0000AA, 1'b0);
        send_word(24'h0000BB, 1'b0);
        chk_eq("s3_in_drop", 32'(bus.wr_state), 32'(DROP));
        send_word(24'h0000CC, 1'b1);
        idle(2);
        chk_eq("s3_drops2", 32'(drop_cnt), 32'd3);
        chk_eq("s3_back_write", 32'(bus.wr_state), 32'(WRITE));
        chk_eq("s3_cnt2", 32'(bus.pkt_count), 32'd8);
        drain("s3");

        // three back-to-back packets with ready toggling each cycle
        bus.data_out_ready = 1'b0;
        fork
            begin
                send_pkt(4, 1'b1, 1'b0);
                send_pkt(6, 1'b1, 1'b0);
                send_pkt(3, 1'b1, 1'b0);
                idle(1);
            end
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    bus.data_out_ready = ~bus.data_out_ready;
                end
            end
        join
        drain("s4");

        // reset after the 3rd word of a packet, with a stored packet on the output
        bus.data_out_ready = 1'b0;
        send_pkt(2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_word(DATA_W'($urandom_range(1, 24'hFFFFFF)), 1'b0);
        @(posedge clk);
        #1;
        bus.data_in_en = 1'b0;
        reset_n        = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
`ifdef GEARBOX_PKT_LEN_EN
        len_q.delete();
`endif
        chk_reset_state("s5");
        reset_n = 1'b1;
        d = DATA_W'($urandom_range(1, 24'hFFFFFF));
        bus.data_in      = d;
        bus.data_in_last = 1'b0;
        bus.data_in_en   = 1'b1;
        exp_q.push_back({1'b0, d});
        for (int i = 1; i < 4; i++) begin
            d = DATA_W'($urandom_range(1, 24'hFFFFFF));
            send_word(d, i == 3);
            exp_q.push_back({i == 3, d});
        end
`ifdef GEARBOX_PKT_LEN_EN
        len_q.push_back(LENW'(4));
`endif
        idle(1);
        drain("s5");

        // lengths 1, 7 and 16; the 16-word packet fills the buffer exactly
        bus.data_out_ready = 1'b1;
        send_pkt(1, 1'b1, 1'b0);
        send_pkt(7, 1'b1, 1'b0);
        idle(1);
        drain("s6a");
        bus.data_out_ready = 1'b0;
        send_pkt(16, 1'b1, 1'b0);
        idle(3);
        chk_eq("s6_full_cnt", 32'(bus.pkt_count), 32'd1);
        chk_eq("s6_no_drop", 32'(drop_cnt), 32'd3);
        drain("s6b");

        chk_eq("total_drops", 32'(drop_cnt), 32'd3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
